// File: rtl/backprop_pkg.sv
// Shared FSM encodings and fixed-point helpers for the streaming backprop engine.
package backprop_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int         DEF_FRAC = 16;
    localparam logic [63:0] ONE     = 64'd1 << DEF_FRAC;

    // Clamp a wide signed value to the signed w-bit range, or pass it through
    // so the caller's truncation wraps it.
    function automatic logic [63:0] sat_w(input logic signed [127:0] x,
                                          input int w,
                                          input logic sat);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (sat && (x > hi)) return hi[63:0];
        if (sat && (x < lo)) return lo[63:0];
        return x[63:0];
    endfunction

endpackage

// File: rtl/backprop_stream_bp_mac_pipe.sv
// Three-stage multiply/shift/accumulate datapath; every stage freezes on stall.
module bp_mac_pipe
    import backprop_pkg::*;
#(
    parameter int IW       = 6,
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int SATURATE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          in_fire,
    input  logic          in_last,
    input  logic [IW-1:0] in_idx,
    input  logic [W-1:0]  in_dendrite,
    input  logic [W-1:0]  in_weight,
    input  logic [W-1:0]  bp,
    input  logic [W-1:0]  train_mul,
    input  logic [5:0]    train_shift,
    output logic          out_valid,
    output logic          out_last,
    output logic [IW-1:0] out_idx,
    output logic [W-1:0]  out_bp_change,
    output logic [W-1:0]  out_weight_new
);

    localparam logic [W-1:0] ONE_W = W'(64'd1 << FRAC);

    logic                  v1_q, v1_d, last1_q, last1_d;
    logic [IW-1:0]         idx1_q, idx1_d;
    logic [W-1:0]          w1_q, w1_d;
    logic signed [2*W-1:0] pd1_q, pd1_d, pw1_q, pw1_d;

    logic                  v2_q, v2_d, last2_q, last2_d;
    logic [IW-1:0]         idx2_q, idx2_d;
    logic [W-1:0]          w2_q, w2_d;
    logic signed [2*W-1:0] pw2_q, pw2_d, sf2_q, sf2_d;

    logic                  v3_q, v3_d, last3_q, last3_d;
    logic [IW-1:0]         idx3_q, idx3_d;
    logic [W-1:0]          bpc3_q, bpc3_d, wn3_q, wn3_d;

    logic [W-1:0]          d_eff, delta;
    logic signed [2*W-1:0] step, pws;
    logic [2*W:0]          sum;

    always_comb begin
        v1_d = v1_q; last1_d = last1_q; idx1_d = idx1_q; w1_d = w1_q;
        pd1_d = pd1_q; pw1_d = pw1_q;
        v2_d = v2_q; last2_d = last2_q; idx2_d = idx2_q; w2_d = w2_q;
        pw2_d = pw2_q; sf2_d = sf2_q;
        v3_d = v3_q; last3_d = last3_q; idx3_d = idx3_q;
        bpc3_d = bpc3_q; wn3_d = wn3_q;

        // The threshold element behaves as if its dendrite were exactly 1.0.
        d_eff = in_last ? ONE_W : in_dendrite;
        delta = W'(pd1_q >>> FRAC);
        step  = sf2_q >>> train_shift;
        sum   = {{(W+1){w2_q[W-1]}}, w2_q} + {step[2*W-1], step};
        pws   = pw2_q >>> FRAC;

        if (!stall) begin
            v1_d = in_fire;
            if (in_fire) begin
                last1_d = in_last;
                idx1_d  = in_idx;
                w1_d    = in_weight;
                pd1_d   = {{W{d_eff[W-1]}}, d_eff} * {{W{bp[W-1]}}, bp};
                pw1_d   = {{W{in_weight[W-1]}}, in_weight} * {{W{bp[W-1]}}, bp};
            end

            v2_d = v1_q;
            if (v1_q) begin
                last2_d = last1_q;
                idx2_d  = idx1_q;
                w2_d    = w1_q;
                pw2_d   = pw1_q;
                sf2_d   = {{W{delta[W-1]}}, delta} * {{W{train_mul[W-1]}}, train_mul};
            end

            v3_d = v2_q;
            if (v2_q) begin
                last3_d = last2_q;
                idx3_d  = idx2_q;
                wn3_d   = W'(sat_w({{(127-2*W){sum[2*W]}}, sum}, W, SATURATE != 0));
                bpc3_d  = last2_q ? '0
                        : W'(sat_w({{(128-2*W){pws[2*W-1]}}, pws}, W, SATURATE != 0));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; last1_q <= 1'b0; idx1_q <= '0; w1_q <= '0;
            pd1_q <= '0; pw1_q <= '0;
            v2_q <= 1'b0; last2_q <= 1'b0; idx2_q <= '0; w2_q <= '0;
            pw2_q <= '0; sf2_q <= '0;
            v3_q <= 1'b0; last3_q <= 1'b0; idx3_q <= '0;
            bpc3_q <= '0; wn3_q <= '0;
        end else begin
            v1_q <= v1_d; last1_q <= last1_d; idx1_q <= idx1_d; w1_q <= w1_d;
            pd1_q <= pd1_d; pw1_q <= pw1_d;
            v2_q <= v2_d; last2_q <= last2_d; idx2_q <= idx2_d; w2_q <= w2_d;
            pw2_q <= pw2_d; sf2_q <= sf2_d;
            v3_q <= v3_d; last3_q <= last3_d; idx3_q <= idx3_d;
            bpc3_q <= bpc3_d; wn3_q <= wn3_d;
        end
    end

    assign out_valid      = v3_q;
    assign out_last       = last3_q;
    assign out_idx        = idx3_q;
    assign out_bp_change  = bpc3_q;
    assign out_weight_new = wn3_q;

endmodule

// File: rtl/backprop_stream.sv
// Job-level sequencing for the one-neuron streaming backprop engine.
module backprop_stream
    import backprop_pkg::*;
#(
    parameter int N        = 32,
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int SATURATE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [W-1:0]           cmd_backprop,
    input  logic [W-1:0]           cmd_train_mul,
    input  logic [5:0]             cmd_train_shift,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_dendrite,
    input  logic [W-1:0]           in_weight,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N+1)-1:0] out_idx,
    output logic                   out_last,
    output logic [W-1:0]           out_bp_change,
    output logic [W-1:0]           out_weight_new
);

    localparam int            IW       = $clog2(N+1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  bp_q, bp_d, mul_q, mul_d;
    logic [5:0]    shift_q, shift_d;
    logic          stall, in_fire;

    assign stall     = out_valid && !out_ready;
    assign cmd_ready = (state_q == ST_IDLE);
    assign in_ready  = (state_q == ST_RUN) && !stall;
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bp_d    = bp_q;
        mul_d   = mul_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                bp_d    = cmd_backprop;
                mul_d   = cmd_train_mul;
                shift_d = cmd_train_shift;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: if (in_fire) begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            ST_DRAIN: if (out_valid && out_ready && out_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bp_q    <= '0;
            mul_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bp_q    <= bp_d;
            mul_q   <= mul_d;
            shift_q <= shift_d;
        end
    end

    bp_mac_pipe #(
        .IW(IW), .W(W), .FRAC(FRAC), .SATURATE(SATURATE)
    ) u_pipe (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .in_fire        (in_fire),
        .in_last        (cnt_q == LAST_IDX),
        .in_idx         (cnt_q),
        .in_dendrite    (in_dendrite),
        .in_weight      (in_weight),
        .bp             (bp_q),
        .train_mul      (mul_q),
        .train_shift    (shift_q),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_idx        (out_idx),
        .out_bp_change  (out_bp_change),
        .out_weight_new (out_weight_new)
    );

endmodule
